pid_cell_core: RTL and testbench

- Compute stage directly downstream of the AXI-lite register cell. Consumes its flat `regs` bus: gains and setpoint.
- Accepts one signed measurement per valid/ready handshake.
- Computes a saturating fixed-point PID control value with one shared multiplier, sequenced by an FSM.
- Presents the result on a valid/ready output stream to the actuator side.

---
 rtl/pid_cell_if.sv | 22 ++
 rtl/pid_cell_core.sv | 196 +++++++++++++++++++
 tb/tb_pid_cell_core.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pid_cell_if.sv
// Measurement-in / control-out stream bundle for the PID compute stage.
// The master drives samples and consumes results. The slave is the core.
interface pid_cell_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] meas_data;
    logic                  meas_valid;
    logic                  meas_ready;
    logic [DATA_WIDTH-1:0] u_data;
    logic                  u_valid;
    logic                  u_ready;

    modport master (
        output meas_data, meas_valid, u_ready,
        input  meas_ready, u_data, u_valid
    );

    modport slave (
        input  meas_data, meas_valid, u_ready,
        output meas_ready, u_data, u_valid
    );
endinterface

// File: rtl/pid_cell_core.sv
// Saturating fixed-point PID stage fed by the register cell's flat regs bus.
// A single shared multiplier is time-multiplexed by a short FSM:
// ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> OUT.
module pid_cell_core #(
    parameter int                    DATA_SIZE   = 128,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    FRAC_BITS   = 16,
    parameter logic [DATA_WIDTH-1:0] INTEG_LIMIT = 32'h3FFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] regs,
    input  logic                 clr_integ,
    pid_cell_if.slave            io,
    output logic                 busy
);
    localparam int DW = DATA_WIDTH;
    localparam int TW = 2 * DW - FRAC_BITS;   // width of each product term
    localparam int SW = TW + 2;               // term sum with guard bits

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ERR   = 3'd1;
    localparam logic [2:0] S_MUL_P = 3'd2;
    localparam logic [2:0] S_MUL_I = 3'd3;
    localparam logic [2:0] S_MUL_D = 3'd4;
    localparam logic [2:0] S_SUM   = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    localparam logic [DW-1:0]        MAX_W   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        MIN_W   = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0] LIM_POS = $signed({2'b00, INTEG_LIMIT});
    localparam logic signed [DW+1:0] LIM_NEG = -LIM_POS;

    // Unpack the regs bus: word0 kp, word1 ki, word2 kd, word3 setpoint.
    logic [DW-1:0] reg_word [4];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_regs
            assign reg_word[gi] = regs[gi*DW +: DW];
        end
    endgenerate

    logic [2:0]           state_q, state_d;
    logic signed [DW-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d;
    logic signed [DW-1:0] meas_q, meas_d, e_q, e_d, d_q, d_d;
    logic signed [DW-1:0] integ_q, integ_d, e_prev_q, e_prev_d;
    logic signed [TW-1:0] tp_q, tp_d, ti_q, ti_d, td_q, td_d;
    logic [DW-1:0]        u_data_q, u_data_d;
    logic                 u_valid_q, u_valid_d;

    logic [DW:0]            err_w;
    logic [DW-1:0]          e_sat;
    logic signed [DW+1:0]   integ_sum;
    logic [DW-1:0]          integ_clamp;
    logic [DW:0]            diff_w;
    logic [DW-1:0]          d_sat;
    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [TW-1:0]   term;
    logic [SW-1:0]          sum_w;
    logic [DW-1:0]          u_sat;

    assign io.meas_ready = (state_q == S_IDLE) & ~clr_integ & ~rst;
    assign io.u_data     = u_data_q;
    assign io.u_valid    = u_valid_q;
    assign busy          = (state_q != S_IDLE);

    // Error, integrator and derivative arithmetic with saturation.
    always_comb begin
        err_w = {sp_q[DW-1], sp_q} - {meas_q[DW-1], meas_q};
        if (err_w[DW] == err_w[DW-1]) e_sat = err_w[DW-1:0];
        else                          e_sat = err_w[DW] ? MIN_W : MAX_W;

        integ_sum = $signed({{2{integ_q[DW-1]}}, integ_q}) + $signed({{2{e_sat[DW-1]}}, e_sat});
        if (integ_sum > LIM_POS)      integ_clamp = LIM_POS[DW-1:0];
        else if (integ_sum < LIM_NEG) integ_clamp = LIM_NEG[DW-1:0];
        else                          integ_clamp = integ_sum[DW-1:0];

        diff_w = {e_sat[DW-1], e_sat} - {e_prev_q[DW-1], e_prev_q};
        if (diff_w[DW] == diff_w[DW-1]) d_sat = diff_w[DW-1:0];
        else                            d_sat = diff_w[DW] ? MIN_W : MAX_W;
    end

    // Shared multiplier: operands selected by state, result floored by the Q shift.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_MUL_P: begin mul_a = kp_q; mul_b = e_q;     end
            S_MUL_I: begin mul_a = ki_q; mul_b = integ_q; end
            S_MUL_D: begin mul_a = kd_q; mul_b = d_q;     end
            default: begin mul_a = '0;   mul_b = '0;      end
        endcase
        prod = $signed({{DW{mul_a[DW-1]}}, mul_a}) * $signed({{DW{mul_b[DW-1]}}, mul_b});
        term = TW'(prod >>> FRAC_BITS);
    end

    // Final term sum saturated to the output word.
    always_comb begin
        sum_w = {{2{tp_q[TW-1]}}, tp_q} + {{2{ti_q[TW-1]}}, ti_q} + {{2{td_q[TW-1]}}, td_q};
        if (sum_w[SW-1:DW-1] == {(SW-DW+1){sum_w[SW-1]}}) u_sat = sum_w[DW-1:0];
        else                                              u_sat = sum_w[SW-1] ? MIN_W : MAX_W;
    end

    // FSM sequencing and next-state of every datapath register.
    always_comb begin
        state_d   = state_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        sp_d      = sp_q;
        meas_d    = meas_q;
        e_d       = e_q;
        d_d       = d_q;
        integ_d   = integ_q;
        e_prev_d  = e_prev_q;
        tp_d      = tp_q;
        ti_d      = ti_q;
        td_d      = td_q;
        u_data_d  = u_data_q;
        u_valid_d = u_valid_q;
        case (state_q)
            S_IDLE: begin
                if (clr_integ) begin
                    integ_d  = '0;
                    e_prev_d = '0;
                end else if (io.meas_valid) begin
                    kp_d    = reg_word[0];
                    ki_d    = reg_word[1];
                    kd_d    = reg_word[2];
                    sp_d    = reg_word[3];
                    meas_d  = io.meas_data;
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                e_d      = e_sat;
                integ_d  = integ_clamp;
                d_d      = d_sat;
                e_prev_d = e_sat;
                state_d  = S_MUL_P;
            end
            S_MUL_P: begin tp_d = term; state_d = S_MUL_I; end
            S_MUL_I: begin ti_d = term; state_d = S_MUL_D; end
            S_MUL_D: begin td_d = term; state_d = S_SUM;   end
            S_SUM: begin
                u_data_d  = u_sat;
                u_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (io.u_ready) begin
                    u_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; rst aborts any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            sp_q      <= '0;
            meas_q    <= '0;
            e_q       <= '0;
            d_q       <= '0;
            integ_q   <= '0;
            e_prev_q  <= '0;
            tp_q      <= '0;
            ti_q      <= '0;
            td_q      <= '0;
            u_data_q  <= '0;
            u_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            sp_q      <= sp_d;
            meas_q    <= meas_d;
            e_q       <= e_d;
            d_q       <= d_d;
            integ_q   <= integ_d;
            e_prev_q  <= e_prev_d;
            tp_q      <= tp_d;
            ti_q      <= ti_d;
            td_q      <= td_d;
            u_data_q  <= u_data_d;
            u_valid_q <= u_valid_d;
        end
    end
endmodule

// File: tb/tb_pid_cell_core.sv
// Scoreboard bench for pid_cell_core: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_pid_cell_core;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] regs = '0;
    logic         clr_integ = 1'b0;
    logic         busy;

    pid_cell_if #(.DATA_WIDTH(32)) bus ();

    pid_cell_core #(
        .DATA_SIZE(128), .DATA_WIDTH(32), .FRAC_BITS(16), .INTEG_LIMIT(32'h3FFFFFFF)
    ) dut (
        .clk(clk), .rst(rst), .regs(regs), .clr_integ(clr_integ), .io(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (!rst && bus.u_valid && bus.u_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=none", bus.u_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                $display("OUT u_data=%h expected=%h", bus.u_data, e);
                chk("u_data", bus.u_data, e);
            end
        end
    end

    task automatic set_regs(input logic [31:0] kp, input logic [31:0] ki,
                            input logic [31:0] kd, input logic [31:0] sp);
        regs = {sp, kd, ki, kp};
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_integ = 1'b1;
        #1 chk("meas_ready_during_clr", {31'b0, bus.meas_ready}, 32'd0);
        @(posedge clk);
        #1 clr_integ = 1'b0;
    endtask

    // Offer one sample; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] meas, input bit push, input logic [31:0] res);
        int n = 0;
        @(negedge clk);
        bus.meas_data  = meas;
        bus.meas_valid = 1'b1;
        while (!bus.meas_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=meas_ready_low required=accept");
            bus.meas_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back(res);
            $display("IN  meas=%h push=%0d expected=%h", meas, push, res);
            @(posedge clk);
            #1 bus.meas_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.meas_data  = '0;
        bus.meas_valid = 1'b0;
        bus.u_ready    = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_u_valid",    {31'b0, bus.u_valid},    32'd0);
        chk("rst_busy",       {31'b0, busy},           32'd0);
        chk("rst_meas_ready", {31'b0, bus.meas_ready}, 32'd0);
        chk("rst_u_data",     bus.u_data,              32'd0);
        rst = 1'b0;
        @(negedge clk);

        // P only, with latency check.
        set_regs(32'h00010000, 0, 0, 32'd100);
        chk("meas_ready_idle", {31'b0, bus.meas_ready}, 32'd1);
        send(32'd40, 1, 32'd60);
        repeat (4) @(posedge clk);
        #1 chk("u_valid_before_cycle6", {31'b0, bus.u_valid}, 32'd0);
        @(posedge clk);
        #1 chk("u_valid_cycle6", {31'b0, bus.u_valid}, 32'd1);
        @(posedge clk);
        #1 chk("meas_ready_after_out", {31'b0, bus.meas_ready}, 32'd1);
        drain();

        // Integrator accumulate and clear.
        clr_pulse();
        set_regs(0, 32'h00010000, 0, 32'd10);
        send(32'd0, 1, 32'd10);
        send(32'd0, 1, 32'd20);
        drain();
        clr_pulse();
        send(32'd0, 1, 32'd10);
        drain();

        // Derivative with floor rounding.
        clr_pulse();
        set_regs(0, 0, 32'h00008000, 32'd0);
        send(32'd0, 1, 32'd0);
        send(32'hFFFFFFFD, 1, 32'd1);
        send(32'd0, 1, 32'hFFFFFFFE);
        drain();

        // Saturation of error, output and integrator.
        clr_pulse();
        set_regs(32'h00020000, 0, 0, 32'h7FFFFFFF);
        send(32'h80000000, 1, 32'h7FFFFFFF);
        drain();
        clr_pulse();
        set_regs(0, 32'h00010000, 0, 32'h7FFFFFFF);
        for (int i = 0; i < 3; i++) send(32'h80000000, 1, 32'h3FFFFFFF);
        set_regs(0, 32'h00010000, 0, 32'h80000000);
        send(32'h7FFFFFFF, 1, 32'hC0000001);
        drain();
        clr_pulse();
        set_regs(32'h00020000, 0, 0, 32'h80000000);
        send(32'h7FFFFFFF, 1, 32'h80000000);
        drain();

        // Backpressure and gain snapshot.
        clr_pulse();
        bus.u_ready = 1'b0;
        set_regs(32'h00010000, 0, 0, 32'd1000);
        send(32'd1, 1, 32'd999);
        @(posedge clk);
        @(posedge clk);
        #1 regs[31:0] = 32'h00050000;
        begin
            int n = 0;
            while (!bus.u_valid && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            chk("bp_u_valid_seen", {31'b0, bus.u_valid}, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_u_data_stable", bus.u_data,              32'd999);
            chk("bp_meas_ready",    {31'b0, bus.meas_ready}, 32'd0);
            chk("bp_busy",          {31'b0, busy},           32'd1);
        end
        @(posedge clk);
        #1 bus.u_ready = 1'b1;
        drain();

        // Reset during MUL_I: no output, history cleared.
        set_regs(32'h00010000, 32'h00010000, 32'h00010000, 32'd50);
        send(32'd0, 0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("busy_before_rst", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("midrst_u_valid",    {31'b0, bus.u_valid},    32'd0);
        chk("midrst_busy",          {31'b0, busy},           32'd0);
        chk("midrst_meas_ready",    {31'b0, bus.meas_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_meas_ready", {31'b0, bus.meas_ready}, 32'd1);
        send(32'd0, 1, 32'd150);
        drain();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
